// File: rtl/opb_register_bank_ppc2simulink_if.sv
// rtl/opb_register_bank_ppc2simulink_if.sv - OPB slave bus bundle for the register bank
//
// Purpose: groups the OPB request signals (master -> slave) and the slave
// response signals (slave -> master) so the register bank takes one port.
// OPB bit numbering is big-endian: bit 0 is the most significant bit.
//
// Signals:
//   OPB_ABus[0:31]   byte address
//   OPB_BE[0:3]      byte enables, BE[0] covers DBus[0:7]
//   OPB_DBus[0:31]   write data
//   OPB_RNW          1 = read, 0 = write
//   OPB_select       transfer request
//   OPB_seqAddr      sequential-address hint (unused by the bank)
//   Sl_DBus[0:31]    read data, zero when not acking
//   Sl_xferAck       transfer acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup  always 0 from the bank
//
// Modports: master drives requests, slave drives responses.

interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - bank of PPC-writable software registers behind one OPB slave
//
// Purpose: N_REGS 32-bit registers in one OPB address window. Each register
// drives a user-side output with byte-lane writes, readback and a one-cycle
// update strobe. Every transfer that hits the window is acked exactly one
// cycle after select is sampled.
//
// Optional feature (macro REGBANK_ATOMIC_COMMIT_EN): writes land in shadow
// registers and mark them dirty; a write to word N_REGS (the commit word)
// copies every shadow to the outputs at once and strobes the dirty ones.
// Reading the commit word returns the dirty mask.
//
// Ports:
//   OPB_Clk         sole clock (bus and user side)
//   OPB_Rst         synchronous active-high reset
//   opb             OPB slave bundle (opb_register_bank_ppc2simulink_if.slave)
//   user_data_out   register k at bits [32k+31:32k]
//   user_wr_strobe  bit k pulses for one cycle when register k's output updates

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01180500,
  parameter logic [31:0] C_HIGHADDR   = 32'h011805FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6",
  parameter int          N_REGS       = 4,
  parameter logic [31:0] RESET_VALUE  = 32'h00000000
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [N_REGS*32-1:0]       user_data_out,
  output logic [N_REGS-1:0]          user_wr_strobe
);

  // Only a 32-bit OPB with 1..63 registers is supported; the upper bound keeps
  // the commit word inside a 256-byte window.
  if (N_REGS < 1 || N_REGS > 63 || C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32
      || C_FAMILY == "") begin : g_bad_cfg
    $error("opb_register_bank_ppc2simulink: unsupported configuration");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [N_REGS-1:0][31:0]        out_q, out_d;
  logic [N_REGS-1:0]              strobe_q, strobe_d;
  logic [C_OPB_DWIDTH-1:0]        rdata_q, rdata_d;

`ifdef REGBANK_ATOMIC_COMMIT_EN
  logic [N_REGS-1:0][31:0]        shadow_q, shadow_d;
  logic [N_REGS-1:0]              dirty_q, dirty_d;
`endif

  // Bus decode. The word index drops the two byte-offset bits, so
  // ABus[30:31] never affects which register is addressed.
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [31:0]             word_idx;
  logic [31:0]             wdata;
  logic [3:0]              be_v;
  logic                    hit;
  logic                    unused_ok;

  assign addr      = opb.OPB_ABus;
  assign offset    = addr - C_BASEADDR;
  assign word_idx  = {2'b00, offset[31:2]};
  assign wdata     = opb.OPB_DBus;
  // OPB_BE[0] lands in be_v[3], which selects register bits 31:24.
  assign be_v      = opb.OPB_BE;
  assign hit       = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign unused_ok = ^{opb.OPB_seqAddr, offset[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    strobe_d = '0;
    rdata_d  = '0;
`ifdef REGBANK_ATOMIC_COMMIT_EN
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Everything a transfer produces is registered here so that ack,
        // read data, the new output and its strobe all appear together in ACK.
        if (hit) begin
          state_d = ST_ACK;
          if (opb.OPB_RNW) begin
            for (int k = 0; k < N_REGS; k++) begin
`ifdef REGBANK_ATOMIC_COMMIT_EN
              if (word_idx == 32'(k)) rdata_d = shadow_q[k];
`else
              if (word_idx == 32'(k)) rdata_d = out_q[k];
`endif
            end
`ifdef REGBANK_ATOMIC_COMMIT_EN
            if (word_idx == 32'(N_REGS)) rdata_d = 32'(dirty_q);
`endif
          end else begin
            for (int k = 0; k < N_REGS; k++) begin
              if (word_idx == 32'(k)) begin
`ifdef REGBANK_ATOMIC_COMMIT_EN
                shadow_d[k] = merge_lanes(shadow_q[k], wdata, be_v);
                dirty_d[k]  = 1'b1;
`else
                out_d[k]    = merge_lanes(out_q[k], wdata, be_v);
                strobe_d[k] = 1'b1;
`endif
              end
            end
`ifdef REGBANK_ATOMIC_COMMIT_EN
            // Commit ignores BE: any write to this word publishes all shadows.
            if (word_idx == 32'(N_REGS)) begin
              out_d    = shadow_q;
              strobe_d = dirty_q;
              dirty_d  = '0;
            end
`endif
          end
        end
      end
      ST_ACK: begin
        // Select is still high here for the acked transfer; it is not resampled.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= ST_IDLE;
      out_q    <= {N_REGS{RESET_VALUE}};
      strobe_q <= '0;
      rdata_q  <= '0;
`ifdef REGBANK_ATOMIC_COMMIT_EN
      shadow_q <= {N_REGS{RESET_VALUE}};
      dirty_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
`ifdef REGBANK_ATOMIC_COMMIT_EN
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
`endif
    end
  end

  assign user_data_out  = out_q;
  assign user_wr_strobe = strobe_q;

  assign opb.Sl_xferAck = (state_q == ST_ACK);
  // OR-bus: drive zero whenever this slave is not acking.
  assign opb.Sl_DBus    = (state_q == ST_ACK) ? rdata_q : '0;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - directed self-checking bench for opb_register_bank_ppc2simulink

module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01180500;
  localparam int          NR   = 4;

  logic              clk;
  logic              rst;
  logic [NR*32-1:0]  user_data_out;
  logic [NR-1:0]     user_wr_strobe;

  opb_register_bank_ppc2simulink_if bus ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (32'h01180500),
    .C_HIGHADDR  (32'h011805FF),
    .N_REGS      (NR),
    .RESET_VALUE (32'h00000000)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .opb            (bus),
    .user_data_out  (user_data_out),
    .user_wr_strobe (user_wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One OPB transfer. Inputs change on the falling edge; the ack cycle's
  // outputs are captured on a falling edge too. lat counts cycles from the
  // cycle select is sampled to the cycle ack is seen (0 = no ack in budget).
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic [127:0] ud, output logic [3:0] stb);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    a = addr; d = wd; b = be;
    @(negedge clk);
    bus.OPB_ABus   = a;
    bus.OPB_DBus   = d;
    bus.OPB_BE     = b;
    bus.OPB_RNW    = rnw;
    bus.OPB_select = 1'b1;
    lat = 0; rd = '0; ud = '0; stb = '0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.Sl_xferAck) begin
        lat = i;
        rd  = bus.Sl_DBus;
        ud  = user_data_out;
        stb = user_wr_strobe;
      end
    end
    bus.OPB_select = 1'b0;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_BE     = '0;
    bus.OPB_DBus   = '0;
  endtask

  // The cycle after an ack: ack, read bus and strobes must all be quiet.
  task automatic check_quiet(input string tag);
    @(negedge clk);
    check_eq({tag, "_ack_off"}, bus.Sl_xferAck, 1'b0);
    check_eq({tag, "_dbus_off"}, bus.Sl_DBus, 32'h0);
    check_eq({tag, "_stb_off"}, user_wr_strobe, 4'b0000);
  endtask

  int           lat;
  int           n_ack;
  logic [31:0]  rd;
  logic [127:0] ud;
  logic [3:0]   stb;

  initial begin
    rst = 1'b1;
    bus.OPB_ABus = '0; bus.OPB_DBus = '0; bus.OPB_BE = '0;
    bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", bus.Sl_xferAck, 1'b0);
    check_eq("rst_dbus", bus.Sl_DBus, 32'h0);
    check_eq("rst_ud", user_data_out, 128'h0);
    check_eq("rst_stb", user_wr_strobe, 4'b0000);
    rst = 1'b0;

    for (int k = 0; k < NR; k++) begin
      xfer(1'b1, BASE + 32'(4*k), 4'hF, 32'h0, lat, rd, ud, stb);
      check_eq($sformatf("rd0_w%0d_lat", k), lat, 1);
      check_eq($sformatf("rd0_w%0d_data", k), rd, 32'h0);
    end
    check_quiet("rd0");

    xfer(1'b0, BASE + 32'd8, 4'b1111, 32'hDEADBEEF, lat, rd, ud, stb);
    check_eq("wr_full_lat", lat, 1);
`ifndef REGBANK_ATOMIC_COMMIT_EN
    check_eq("wr_full_ud", ud, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    check_eq("wr_full_stb", stb, 4'b0100);
`endif
    check_quiet("wr_full");
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("rb_full", rd, 32'hDEADBEEF);

    xfer(1'b0, BASE + 32'd8, 4'b0101, 32'h11223344, lat, rd, ud, stb);
`ifndef REGBANK_ATOMIC_COMMIT_EN
    check_eq("wr_lane_ud", ud, {32'h0, 32'hDE22BE44, 32'h0, 32'h0});
    check_eq("wr_lane_stb", stb, 4'b0100);
`endif
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("rb_lane", rd, 32'hDE22BE44);

    // BE=0000 still acks and leaves the register alone.
    xfer(1'b0, BASE + 32'd8, 4'b0000, 32'h55555555, lat, rd, ud, stb);
    check_eq("wr_be0_lat", lat, 1);
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("rb_be0", rd, 32'hDE22BE44);

    // Byte-offset bits of the address are ignored.
    xfer(1'b0, BASE + 32'd7, 4'b1111, 32'h01020304, lat, rd, ud, stb);
`ifndef REGBANK_ATOMIC_COMMIT_EN
    check_eq("wr_off_stb", stb, 4'b0010);
`endif
    xfer(1'b1, BASE + 32'd5, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("rb_off", rd, 32'h01020304);

    // Word N_REGS+1 is in the window but unbacked.
    xfer(1'b0, BASE + 32'd20, 4'b1111, 32'hFFFFFFFF, lat, rd, ud, stb);
    check_eq("oob_wr_lat", lat, 1);
`ifndef REGBANK_ATOMIC_COMMIT_EN
    check_eq("oob_wr_stb", stb, 4'b0000);
    check_eq("oob_wr_ud", ud, {32'h0, 32'hDE22BE44, 32'h01020304, 32'h0});
    xfer(1'b0, BASE + 32'd16, 4'b1111, 32'hFFFFFFFF, lat, rd, ud, stb);
    check_eq("oob4_wr_stb", stb, 4'b0000);
    xfer(1'b1, BASE + 32'd16, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("oob4_rd", rd, 32'h0);
`endif
    xfer(1'b1, BASE + 32'd20, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("oob_rd_lat", lat, 1);
    check_eq("oob_rd_data", rd, 32'h0);

    // Outside the window: no ack at all.
    xfer(1'b1, 32'h01180600, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("above_win_lat", lat, 0);
    xfer(1'b0, 32'h011804FC, 4'hF, 32'hFFFFFFFF, lat, rd, ud, stb);
    check_eq("below_win_lat", lat, 0);
    xfer(1'b1, 32'h011805FC, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("top_word_lat", lat, 1);

    // Select held high: a new transfer starts in the IDLE cycle after each ack.
    @(negedge clk);
    bus.OPB_ABus = BASE + 32'd8; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.Sl_xferAck) n_ack++;
    end
    bus.OPB_select = 1'b0;
    check_eq("b2b_acks", n_ack, 2);

    // Reset asserted during the ACK cycle of a write.
    @(negedge clk);
    bus.OPB_ABus = BASE + 32'd12; bus.OPB_DBus = 32'h12345678; bus.OPB_BE = 4'hF;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b1;
    @(negedge clk);
    check_eq("rstack_in_ack", bus.Sl_xferAck, 1'b1);
    rst = 1'b1;
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b1;
    @(negedge clk);
    check_eq("rstack_ack", bus.Sl_xferAck, 1'b0);
    check_eq("rstack_ud", user_data_out, 128'h0);
    check_eq("rstack_stb", user_wr_strobe, 4'b0000);
    rst = 1'b0;
    xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("rstack_rb_lat", lat, 1);
    check_eq("rstack_rb_w2", rd, 32'h0);

`ifdef REGBANK_ATOMIC_COMMIT_EN
    xfer(1'b0, BASE + 32'd0, 4'hF, 32'h0000000A, lat, rd, ud, stb);
    check_eq("cm_w0_ud", ud, 128'h0);
    check_eq("cm_w0_stb", stb, 4'b0000);
    xfer(1'b0, BASE + 32'd12, 4'hF, 32'h0000000B, lat, rd, ud, stb);
    check_eq("cm_w3_ud", ud, 128'h0);
    xfer(1'b1, BASE + 32'd16, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("cm_dirty", rd, 32'h9);
    xfer(1'b0, BASE + 32'd16, 4'b0000, 32'h0, lat, rd, ud, stb);
    check_eq("cm_commit_ud", ud, {32'hB, 32'h0, 32'h0, 32'hA});
    check_eq("cm_commit_stb", stb, 4'b1001);
    check_quiet("cm_commit");
    xfer(1'b1, BASE + 32'd16, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("cm_dirty_clr", rd, 32'h0);
    xfer(1'b0, BASE + 32'd16, 4'hF, 32'h0, lat, rd, ud, stb);
    check_eq("cm_empty_stb", stb, 4'b0000);
    check_eq("cm_empty_ud", ud, {32'hB, 32'h0, 32'h0, 32'hA});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
